// File: rtl/pd_sched.sv
// pd_sched: time-multiplexed PD-term scheduler stepping pitch, roll, yaw through one shared engine.
// Optional PD_SCHED_WARMUP_EN forces D terms to 0 until the D-queue has filled once.
module pd_sched #(
    parameter int               D_QUEUE_DEPTH = 14,
    parameter logic signed [5:0] D_COEFF       = 6'sd7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vld,
    input  logic signed [15:0] ptch,
    input  logic signed [15:0] roll,
    input  logic signed [15:0] yaw,
    input  logic signed [15:0] d_ptch,
    input  logic signed [15:0] d_roll,
    input  logic signed [15:0] d_yaw,
    output logic signed [9:0]  ptch_pterm,
    output logic signed [9:0]  roll_pterm,
    output logic signed [9:0]  yaw_pterm,
    output logic signed [11:0] ptch_dterm,
    output logic signed [11:0] roll_dterm,
    output logic signed [11:0] yaw_dterm,
    output logic               terms_vld,
    output logic               busy,
    output logic               dropped
);
    localparam int PW = $clog2(D_QUEUE_DEPTH);

    typedef enum logic [2:0] {IDLE, P_RD, P_WR, R_RD, R_WR, Y_RD, Y_WR, DONE} state_t;

    state_t state_q, state_d;
    logic rd_en, wr_en, done;
    logic [1:0] axis;

    logic signed [15:0] act_q [3];
    logic signed [15:0] des_q [3];
    logic signed [9:0]  e_q, old_q;
    logic signed [9:0]  pst_q [3];
    logic signed [11:0] dst_q [3];
    logic signed [9:0]  que_q [3][D_QUEUE_DEPTH];
    logic [PW-1:0]      wr_ptr_q;

    logic signed [16:0] err;
    logic signed [9:0]  e_sat, pterm;
    logic signed [10:0] diff;
    logic signed [5:0]  d_sat;
    logic signed [11:0] dterm;
    logic d_gate;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (vld ? P_RD : IDLE) :
                  (state_q == DONE) ? IDLE : state_t'(state_q + 3'd1);
    end

    always_comb begin
        busy  = state_q != IDLE;
        rd_en = state_q inside {P_RD, R_RD, Y_RD};
        wr_en = state_q inside {P_WR, R_WR, Y_WR};
        done  = state_q == DONE;
        axis  = (state_q inside {P_RD, P_WR}) ? 2'd0 : (state_q inside {R_RD, R_WR}) ? 2'd1 : 2'd2;
    end

    always_comb begin
        err   = 17'(act_q[axis]) - 17'(des_q[axis]);
        e_sat = (err > 17'sd511) ? 10'sd511 : (err < -17'sd512) ? -10'sd512 : err[9:0];
        pterm = (e_q >>> 1) + (e_q >>> 3);
        diff  = 11'(e_q) - 11'(old_q);
        d_sat = (diff > 11'sd31) ? 6'sd31 : (diff < -11'sd32) ? -6'sd32 : diff[5:0];
        dterm = 12'(d_sat) * 12'(D_COEFF);
    end

`ifdef PD_SCHED_WARMUP_EN
    localparam int CW = $clog2(D_QUEUE_DEPTH + 1);
    logic [CW-1:0] warm_q;
    always_ff @(posedge clk) begin
        if (rst)                                      warm_q <= '0;
        else if (done && warm_q != CW'(D_QUEUE_DEPTH)) warm_q <= warm_q + CW'(1);
    end
    assign d_gate = warm_q == CW'(D_QUEUE_DEPTH);
`else
    assign d_gate = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            act_q      <= '{default: '0};
            des_q      <= '{default: '0};
            e_q        <= '0;
            old_q      <= '0;
            pst_q      <= '{default: '0};
            dst_q      <= '{default: '0};
            que_q      <= '{default: '{default: '0}};
            wr_ptr_q   <= '0;
            ptch_pterm <= '0;
            roll_pterm <= '0;
            yaw_pterm  <= '0;
            ptch_dterm <= '0;
            roll_dterm <= '0;
            yaw_dterm  <= '0;
            terms_vld  <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            if (state_q == IDLE && vld) begin
                act_q <= '{ptch, roll, yaw};
                des_q <= '{d_ptch, d_roll, d_yaw};
            end
            if (rd_en) begin
                e_q   <= e_sat;
                old_q <= que_q[axis][wr_ptr_q];
            end
            if (wr_en) begin
                pst_q[axis]           <= pterm;
                dst_q[axis]           <= dterm;
                que_q[axis][wr_ptr_q] <= e_q;
            end
            // Outputs move only here so the mixer always sees a coherent set of six terms.
            if (done) begin
                ptch_pterm <= pst_q[0];
                roll_pterm <= pst_q[1];
                yaw_pterm  <= pst_q[2];
                ptch_dterm <= d_gate ? dst_q[0] : '0;
                roll_dterm <= d_gate ? dst_q[1] : '0;
                yaw_dterm  <= d_gate ? dst_q[2] : '0;
                wr_ptr_q   <= (wr_ptr_q == PW'(D_QUEUE_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            terms_vld <= done;
            dropped   <= busy && vld;
        end
    end
endmodule

// File: tb/tb_pd_sched.sv
// tb_pd_sched: randomized self-checking bench for pd_sched against a per-axis error-history model.
module tb_pd_sched;
    localparam int DEPTH = 14;

    logic clk = 1'b0, rst = 1'b1, vld = 1'b0;
    logic signed [15:0] ptch = '0, roll = '0, yaw = '0, d_ptch = '0, d_roll = '0, d_yaw = '0;
    logic signed [9:0]  ptch_pterm, roll_pterm, yaw_pterm;
    logic signed [11:0] ptch_dterm, roll_dterm, yaw_dterm;
    logic terms_vld, busy, dropped;

    pd_sched dut (
        .clk(clk), .rst(rst), .vld(vld),
        .ptch(ptch), .roll(roll), .yaw(yaw),
        .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw),
        .ptch_pterm(ptch_pterm), .roll_pterm(roll_pterm), .yaw_pterm(yaw_pterm),
        .ptch_dterm(ptch_dterm), .roll_dterm(roll_dterm), .yaw_dterm(yaw_dterm),
        .terms_vld(terms_vld), .busy(busy), .dropped(dropped)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int tv_cnt = 0;
    int hist [3][$];
    int n_acc = 0;
    int exp_p [3] = '{0, 0, 0};
    int exp_d [3] = '{0, 0, 0};

    always @(posedge clk) if (terms_vld === 1'b1) tv_cnt++;

    function automatic int clamp(int v, int lo, int hi);
        return v < lo ? lo : (v > hi ? hi : v);
    endfunction

    function automatic int fdiv(int v, int k);
        return (v - (((v % k) + k) % k)) / k;
    endfunction

    function automatic int rv();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                           : int'($urandom_range(0, 1400)) - 700;
    endfunction

    task automatic model_reset();
        for (int ax = 0; ax < 3; ax++) begin
            hist[ax].delete();
            exp_p[ax] = 0;
            exp_d[ax] = 0;
        end
        n_acc = 0;
    endtask

    // Old error is the one accepted DEPTH samples ago, or 0 if fewer exist.
    task automatic model_step(input int a [3], input int d [3]);
        int e, old;
        n_acc++;
        for (int ax = 0; ax < 3; ax++) begin
            e   = clamp(a[ax] - d[ax], -512, 511);
            old = (hist[ax].size() >= DEPTH) ? hist[ax][hist[ax].size() - DEPTH] : 0;
            hist[ax].push_back(e);
            exp_p[ax] = fdiv(e, 2) + fdiv(e, 8);
            exp_d[ax] = clamp(e - old, -32, 31) * 7;
`ifdef PD_SCHED_WARMUP_EN
            if (n_acc <= DEPTH) exp_d[ax] = 0;
`endif
        end
    endtask

    task automatic drive(input int a [3], input int d [3]);
        ptch = 16'(a[0]); roll = 16'(a[1]); yaw = 16'(a[2]);
        d_ptch = 16'(d[0]); d_roll = 16'(d[1]); d_yaw = 16'(d[2]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic sample(input int a0, a1, a2, d0, d1, d2);
        logic [65:0] ev, ov;
        @(negedge clk);
        checks++;
        if (terms_vld !== 1'b0) begin errors++; $display("FAIL pulse_width terms_vld=%b want 0", terms_vld); end
        drive('{a0, a1, a2}, '{d0, d1, d2});
        vld = 1'b1;
        model_step('{a0, a1, a2}, '{d0, d1, d2});
        @(negedge clk);
        vld = 1'b0;
        drive('{rv(), rv(), rv()}, '{rv(), rv(), rv()});
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_start busy=%b want 1", busy); end
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || terms_vld !== 1'b0)
                begin errors++; $display("FAIL busy_seq cyc=%0d busy=%b terms_vld=%b want 1/0", i, busy, terms_vld); end
        end
        @(negedge clk);
        checks++;
        if (terms_vld !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL done terms_vld=%b busy=%b want 1/0", terms_vld, busy); end
        ev = {10'(exp_p[0]), 10'(exp_p[1]), 10'(exp_p[2]), 12'(exp_d[0]), 12'(exp_d[1]), 12'(exp_d[2])};
        ov = {ptch_pterm, roll_pterm, yaw_pterm, ptch_dterm, roll_dterm, yaw_dterm};
        checks++;
        if (ov !== ev) begin errors++; $display("FAIL terms n=%0d got=%h want=%h", n_acc, ov, ev); end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ptch_pterm, roll_pterm, yaw_pterm, ptch_dterm, roll_dterm, yaw_dterm, terms_vld, busy, dropped} !== '0)
            begin errors++; $display("FAIL reset_state p=%0d/%0d/%0d d=%0d/%0d/%0d tv=%b b=%b dr=%b want all 0",
                ptch_pterm, roll_pterm, yaw_pterm, ptch_dterm, roll_dterm, yaw_dterm, terms_vld, busy, dropped); end
    endtask

    task automatic test_vectors();
        logic [65:0] ov, ev;
        do_reset();
        sample(100, 1000, -1000, 0, 0, 0);
`ifdef PD_SCHED_WARMUP_EN
        ev = {10'h03E, 10'h13E, 10'h2C0, 12'h000, 12'h000, 12'h000};
`else
        ev = {10'h03E, 10'h13E, 10'h2C0, 12'h0D9, 12'h0D9, 12'hF20};
`endif
        ov = {ptch_pterm, roll_pterm, yaw_pterm, ptch_dterm, roll_dterm, yaw_dterm};
        checks++;
        if (ov !== ev) begin errors++; $display("FAIL vectors got=%h want=%h", ov, ev); end
    endtask

    task automatic test_const();
        int wd;
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            sample(100, 0, 0, 0, 0, 0);
`ifdef PD_SCHED_WARMUP_EN
            wd = 0;
`else
            wd = (i < 15) ? 217 : 0;
`endif
            checks++;
            if (int'(ptch_dterm) != wd || int'(ptch_pterm) != 62)
                begin errors++; $display("FAIL const i=%0d pterm=%0d dterm=%0d want 62/%0d", i, ptch_pterm, ptch_dterm, wd); end
        end
    endtask

    task automatic test_dropped();
        int base;
        logic [65:0] ov, ev;
        int a [3], d [3];
        a = '{rv(), rv(), rv()}; d = '{rv(), rv(), rv()};
        @(negedge clk);
        drive(a, d); vld = 1'b1; model_step(a, d);
        base = tv_cnt;
        @(negedge clk);
        vld = 1'b0;
        checks++;
        if (dropped !== 1'b0) begin errors++; $display("FAIL drop_accept dropped=%b want 0", dropped); end
        @(negedge clk);
        @(negedge clk);
        drive('{rv(), rv(), rv()}, '{rv(), rv(), rv()}); vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        checks++;
        if (dropped !== 1'b1) begin errors++; $display("FAIL drop_k3 dropped=%b want 1", dropped); end
        @(negedge clk);
        checks++;
        if (dropped !== 1'b0) begin errors++; $display("FAIL drop_width dropped=%b want 0", dropped); end
        @(negedge clk);
        @(negedge clk);
        drive('{rv(), rv(), rv()}, '{rv(), rv(), rv()}); vld = 1'b1;
        @(negedge clk);
        checks++;
        if (dropped !== 1'b1 || terms_vld !== 1'b1)
            begin errors++; $display("FAIL drop_k7 dropped=%b terms_vld=%b want 1/1", dropped, terms_vld); end
        ev = {10'(exp_p[0]), 10'(exp_p[1]), 10'(exp_p[2]), 12'(exp_d[0]), 12'(exp_d[1]), 12'(exp_d[2])};
        ov = {ptch_pterm, roll_pterm, yaw_pterm, ptch_dterm, roll_dterm, yaw_dterm};
        checks++;
        if (ov !== ev) begin errors++; $display("FAIL drop_terms got=%h want=%h", ov, ev); end
        a = '{rv(), rv(), rv()}; d = '{rv(), rv(), rv()};
        drive(a, d); model_step(a, d);
        @(negedge clk);
        vld = 1'b0;
        checks++;
        if (tv_cnt - base != 1 || dropped !== 1'b0 || busy !== 1'b1)
            begin errors++; $display("FAIL drop_k8 pulses=%0d dropped=%b busy=%b want 1/0/1", tv_cnt - base, dropped, busy); end
        repeat (7) @(negedge clk);
        ev = {10'(exp_p[0]), 10'(exp_p[1]), 10'(exp_p[2]), 12'(exp_d[0]), 12'(exp_d[1]), 12'(exp_d[2])};
        ov = {ptch_pterm, roll_pterm, yaw_pterm, ptch_dterm, roll_dterm, yaw_dterm};
        checks++;
        if (terms_vld !== 1'b1 || ov !== ev)
            begin errors++; $display("FAIL back_to_back tv=%b got=%h want=%h", terms_vld, ov, ev); end
    endtask

    task automatic test_mid_reset();
        int base;
        do_reset();
        sample(100, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive('{rv(), rv(), rv()}, '{rv(), rv(), rv()}); vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        base = tv_cnt;
        checks++;
        if ({ptch_pterm, roll_pterm, yaw_pterm, ptch_dterm, roll_dterm, yaw_dterm, terms_vld, busy} !== '0)
            begin errors++; $display("FAIL mid_reset_outs p=%0d d=%0d busy=%b want 0", ptch_pterm, ptch_dterm, busy); end
        repeat (10) @(negedge clk);
        checks++;
        if (tv_cnt != base) begin errors++; $display("FAIL mid_reset_pulse pulses=%0d want 0", tv_cnt - base); end
        rst = 1'b1; vld = 1'b1;
        @(negedge clk);
        rst = 1'b0; vld = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_priority busy=%b want 0", busy); end
        sample(100, 0, 0, 0, 0, 0);
        checks++;
`ifdef PD_SCHED_WARMUP_EN
        if (ptch_dterm !== 12'sd0) begin errors++; $display("FAIL first_after_reset dterm=%0d want 0", ptch_dterm); end
`else
        if (ptch_dterm !== 12'sd217) begin errors++; $display("FAIL first_after_reset dterm=%0d want 217", ptch_dterm); end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 40; i++) sample(rv(), rv(), rv(), rv(), rv(), rv());
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_const();
        test_dropped();
        test_mid_reset();
        test_random();
        test_dropped();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
